lfsr_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 22-bit LFSR pseudo-random source among several requesters. It owns the LFSR's shift-enable and reset lines and advances the register a fixed number of steps per grant. It returns a fresh 22-bit word, tagged with the requester id, and counts LFSR period wraps for health monitoring.

---
 rtl/lfsr_rr_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_lfsr_rr_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_scheduler.sv
// -----------------------------------------------------------------------------
// lfsr_rr_scheduler
//
// Shares one external 22-bit LFSR among N_REQ requesters. A winner is picked
// round robin in IDLE. The scheduler pulses the LFSR shift enable for STEPS
// cycles and then delivers the fresh LFSR word, tagged with the winner id.
// It also counts LFSR period wraps, seen as rising edges of lfsr_max_tick.
//
// Parameters
//   N_REQ  number of requesters (2..8)
//   STEPS  LFSR shifts per delivered word (1..255)
//   IDW    width of rid; 2**IDW must be >= N_REQ
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous reset, active HIGH (despite the name)
//   req            level request per requester, sampled only in IDLE
//   lfsr_q         current LFSR state
//   lfsr_max_tick  LFSR period-complete flag
//   lfsr_sh_en     LFSR shift enable, high in every SHIFT cycle
//   lfsr_rst       LFSR reseed; high in reset and for one cycle after release
//   gnt            one-hot grant, valid with rvalid
//   rdata          delivered word; holds its value until the next delivery
//   rvalid         one-cycle delivery strobe
//   rid            index of the granted requester, valid with rvalid
//   busy           high in SHIFT and DELIVER
//   wrap_cnt       saturating count of LFSR period wraps
//
// Build option
//   LFSR_SCHED_PRIO_EN  When this is defined, requester 0 has fixed top
//                       priority and does not move the round-robin pointer.
//                       Requesters 1..N_REQ-1 rotate among themselves.
// -----------------------------------------------------------------------------
module lfsr_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int STEPS = 1,
    parameter int IDW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [21:0]      lfsr_q,
    input  logic             lfsr_max_tick,
    output logic             lfsr_sh_en,
    output logic             lfsr_rst,
    output logic [N_REQ-1:0] gnt,
    output logic [21:0]      rdata,
    output logic             rvalid,
    output logic [IDW-1:0]   rid,
    output logic             busy,
    output logic [7:0]       wrap_cnt
);

    localparam logic [7:0]     STEPS_L  = STEPS[7:0];
    localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;          // last round-robin winner
    logic [IDW-1:0]   winner_q, winner_d;      // requester being served
    logic             upd_last_q, upd_last_d;  // winner moves the pointer
    logic [7:0]       step_cnt_q, step_cnt_d;  // shifts still to issue
    logic [21:0]      rdata_q, rdata_d;        // word from the last delivery
    logic             tick_prev_q, tick_prev_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
    logic             lfsr_rst_q, lfsr_rst_d;

    // -------------------------------------------------------------------------
    // Round-robin search
    // The search starts at last_q+1 and wraps around. It runs as two passes
    // over the request vector: first the lowest set index above last_q, then
    // the lowest set index at or below last_q.
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] rr_req;
    logic [IDW-1:0]   idx_hi, idx_lo, rr_idx;
    logic             found_hi, found_lo, rr_found;

    always_comb begin
        rr_req = req;
`ifdef LFSR_SCHED_PRIO_EN
        // Requester 0 is handled by the fixed-priority path, so it is
        // removed from the rotation.
        rr_req[0] = 1'b0;
`endif
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        // The loop runs downward, so the last write is the lowest set index.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rr_req[j]) begin
                if (j > int'(last_q)) begin
                    idx_hi   = IDW'(j);
                    found_hi = 1'b1;
                end else begin
                    idx_lo   = IDW'(j);
                    found_lo = 1'b1;
                end
            end
        end
        rr_idx   = found_hi ? idx_hi : idx_lo;
        rr_found = found_hi | found_lo;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        winner_d   = winner_q;
        upd_last_d = upd_last_q;
        step_cnt_d = step_cnt_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            IDLE: begin
`ifdef LFSR_SCHED_PRIO_EN
                if (req[0]) begin
                    winner_d   = '0;
                    upd_last_d = 1'b0;
                    step_cnt_d = STEPS_L;
                    state_d    = SHIFT;
                end else if (rr_found) begin
                    winner_d   = rr_idx;
                    upd_last_d = 1'b1;
                    step_cnt_d = STEPS_L;
                    state_d    = SHIFT;
                end
`else
                if (rr_found) begin
                    winner_d   = rr_idx;
                    upd_last_d = 1'b1;
                    step_cnt_d = STEPS_L;
                    state_d    = SHIFT;
                end
`endif
            end

            SHIFT: begin
                step_cnt_d = step_cnt_q - 8'd1;
                if (step_cnt_q == 8'd1) begin
                    state_d = DELIVER;
                    // The pointer moves only on entry to DELIVER. A reset
                    // during SHIFT therefore leaves no trace of the grant.
                    if (upd_last_q) begin
                        last_d = winner_q;
                    end
                end
            end

            DELIVER: begin
                // LFSR does not shift in DELIVER, so lfsr_q is stable here.
                rdata_d = lfsr_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Wrap monitor and LFSR reseed
    // -------------------------------------------------------------------------
    always_comb begin
        tick_prev_d = lfsr_max_tick;
        wrap_cnt_d  = wrap_cnt_q;
        if (lfsr_max_tick && !tick_prev_q && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
        // Registered copy of reset. This keeps the LFSR reseeding for one
        // cycle after release, so the first grant starts from the seed.
        lfsr_rst_d = rst_n;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            winner_q    <= '0;
            upd_last_q  <= 1'b0;
            step_cnt_q  <= '0;
            rdata_q     <= '0;
            tick_prev_q <= 1'b0;
            wrap_cnt_q  <= '0;
            lfsr_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            upd_last_q  <= upd_last_d;
            step_cnt_q  <= step_cnt_d;
            rdata_q     <= rdata_d;
            tick_prev_q <= tick_prev_d;
            wrap_cnt_q  <= wrap_cnt_d;
            lfsr_rst_q  <= lfsr_rst_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from the state register, or taken straight from flops
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign gnt[gi] = (state_q == DELIVER) && (winner_q == IDW'(gi));
        end
    endgenerate

    assign lfsr_sh_en = (state_q == SHIFT);
    assign rvalid     = (state_q == DELIVER);
    assign busy       = (state_q == SHIFT) || (state_q == DELIVER);
    assign rid        = (state_q == DELIVER) ? winner_q : '0;
    assign wrap_cnt   = wrap_cnt_q;
    assign lfsr_rst   = lfsr_rst_q;

    // The last SHIFT cycle's shift lands in the LFSR register at the edge
    // that enters DELIVER. The word is therefore read from lfsr_q (which is
    // itself a register) while rvalid is high, and rdata_q holds it after.
    assign rdata = (state_q == DELIVER) ? lfsr_q : rdata_q;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
module tb_lfsr_rr_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two schedulers run side by side: u_a with STEPS=1 and u_b with STEPS=5.
    logic        rst_a, rst_b;
    logic [3:0]  req_a, req_b;
    logic        tick_a, tick_b;
    logic        sh_a, sh_b, lrst_a, lrst_b;
    logic [3:0]  gnt_a, gnt_b;
    logic [21:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, busy_a, busy_b;
    logic [2:0]  rid_a, rid_b;
    logic [7:0]  wrap_a, wrap_b;

    localparam logic [21:0] SEED = 22'h000001;
    logic [21:0] lq_a = SEED;
    logic [21:0] lq_b = SEED;

    // Fibonacci LFSR with polynomial x^22 + x^21 + 1, seeded with 1.
    // From the seed, the first 20 shifts only walk the 1 bit up, so the
    // values after k shifts are easy to compute by hand: 1 << k.
    function automatic logic [21:0] lfsr_step(input logic [21:0] s);
        return {s[20:0], s[21] ^ s[20]};
    endfunction

    always @(posedge clk) begin
        if (lrst_a === 1'b1) lq_a <= SEED;
        else if (sh_a === 1'b1) lq_a <= lfsr_step(lq_a);
        if (lrst_b === 1'b1) lq_b <= SEED;
        else if (sh_b === 1'b1) lq_b <= lfsr_step(lq_b);
    end

    lfsr_rr_scheduler #(.N_REQ(4), .STEPS(1), .IDW(3)) u_a (
        .clk(clk), .rst_n(rst_a), .req(req_a), .lfsr_q(lq_a),
        .lfsr_max_tick(tick_a), .lfsr_sh_en(sh_a), .lfsr_rst(lrst_a),
        .gnt(gnt_a), .rdata(rdata_a), .rvalid(rvalid_a), .rid(rid_a),
        .busy(busy_a), .wrap_cnt(wrap_a)
    );

    lfsr_rr_scheduler #(.N_REQ(4), .STEPS(5), .IDW(3)) u_b (
        .clk(clk), .rst_n(rst_b), .req(req_b), .lfsr_q(lq_b),
        .lfsr_max_tick(tick_b), .lfsr_sh_en(sh_b), .lfsr_rst(lrst_b),
        .gnt(gnt_b), .rdata(rdata_b), .rvalid(rvalid_b), .rid(rid_b),
        .busy(busy_b), .wrap_cnt(wrap_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]  rid;
        logic [3:0]  gnt;
        logic [21:0] rdata;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic mon_en   = 1'b0;
    logic gap_en_a = 1'b0;

    task automatic push_a(input logic [2:0] r, input logic [21:0] d);
        exp_t e;
        e.rid = r; e.gnt = 4'b0001 << r; e.rdata = d;
        q_a.push_back(e);
        $display("push A: rid=%0d rdata=%06h", r, d);
    endtask

    task automatic push_b(input logic [2:0] r, input logic [21:0] d);
        exp_t e;
        e.rid = r; e.gnt = 4'b0001 << r; e.rdata = d;
        q_b.push_back(e);
        $display("push B: rid=%0d rdata=%06h", r, d);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected entry on each rvalid. It also checks the
    // number of shift cycles before each delivery and, when enabled, the
    // spacing between deliveries.
    initial begin
        exp_t e;
        int run_a, run_b, last_rv_a;
        run_a = 0; run_b = 0; last_rv_a = -1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rvalid_a === 1'b1) begin
                    if (q_a.size() == 0) begin
                        chk("a_unexpected_rvalid", 1, 0);
                    end else begin
                        e = q_a.pop_front();
                        $display("deliver A: rid=%0d gnt=%b rdata=%06h", rid_a, gnt_a, rdata_a);
                        chk("a_rid", 32'(rid_a), 32'(e.rid));
                        chk("a_gnt", 32'(gnt_a), 32'(e.gnt));
                        chk("a_rdata", 32'(rdata_a), 32'(e.rdata));
                        chk("a_shift_run", run_a, 1);
                    end
                    if (gap_en_a && last_rv_a >= 0) chk("a_rvalid_gap", cyc - last_rv_a, 3);
                    last_rv_a = cyc;
                    run_a = 0;
                end else begin
                    chk("a_gnt_idle", 32'(gnt_a), 0);
                    run_a = (sh_a === 1'b1) ? run_a + 1 : 0;
                end
                if (!gap_en_a) last_rv_a = -1;

                if (rvalid_b === 1'b1) begin
                    if (q_b.size() == 0) begin
                        chk("b_unexpected_rvalid", 1, 0);
                    end else begin
                        e = q_b.pop_front();
                        $display("deliver B: rid=%0d gnt=%b rdata=%06h", rid_b, gnt_b, rdata_b);
                        chk("b_rid", 32'(rid_b), 32'(e.rid));
                        chk("b_gnt", 32'(gnt_b), 32'(e.gnt));
                        chk("b_rdata", 32'(rdata_b), 32'(e.rdata));
                        chk("b_shift_run", run_b, 5);
                    end
                    run_b = 0;
                end else begin
                    chk("b_gnt_idle", 32'(gnt_b), 0);
                    run_b = (sh_b === 1'b1) ? run_b + 1 : 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0;   req_b = '0;
        tick_a = 1'b0; tick_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_gnt", 32'(gnt_a), 0);
        chk("rst_rvalid", 32'(rvalid_a), 0);
        chk("rst_rid", 32'(rid_a), 0);
        chk("rst_rdata", 32'(rdata_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_sh_en", 32'(sh_a), 0);
        chk("rst_wrap", 32'(wrap_a), 0);
        chk("rst_lfsr_rst", 32'(lrst_a), 1);
        chk("rst_b_busy", 32'(busy_b), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("lfsr_rst_released", 32'(lrst_a), 0);

        // Single request, STEPS=1
        req_a = 4'b0001;
        push_a(3'd0, 22'h000002);
        @(negedge clk);
        req_a = '0;
        chk("t1_sh_en_c1", 32'(sh_a), 1);
        chk("t1_busy_c1", 32'(busy_a), 1);
        chk("t1_rvalid_c1", 32'(rvalid_a), 0);
        @(negedge clk);
        chk("t1_rvalid_c2", 32'(rvalid_a), 1);
        chk("t1_sh_en_c2", 32'(sh_a), 0);
        @(negedge clk);
        chk("t1_rvalid_c3", 32'(rvalid_a), 0);
        chk("t1_busy_c3", 32'(busy_a), 0);
        chk("t1_rdata_hold", 32'(rdata_a), 32'h000002);

        // Full request vector held, STEPS=1
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        gap_en_a = 1'b1;
`ifdef LFSR_SCHED_PRIO_EN
        push_a(3'd0, 22'h000002); push_a(3'd0, 22'h000004); push_a(3'd0, 22'h000008);
        push_a(3'd0, 22'h000010); push_a(3'd0, 22'h000020);
`else
        push_a(3'd0, 22'h000002); push_a(3'd1, 22'h000004); push_a(3'd2, 22'h000008);
        push_a(3'd3, 22'h000010); push_a(3'd0, 22'h000020);
`endif
        req_a = 4'b1111;
        repeat (13) @(negedge clk);
        req_a = '0;
        repeat (4) @(negedge clk);
        gap_en_a = 1'b0;

        // Request vector without requester 0: rotation 1,2,3,1
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        gap_en_a = 1'b1;
        push_a(3'd1, 22'h000002); push_a(3'd2, 22'h000004);
        push_a(3'd3, 22'h000008); push_a(3'd1, 22'h000010);
        req_a = 4'b1110;
        repeat (10) @(negedge clk);
        req_a = '0;
        repeat (4) @(negedge clk);
        gap_en_a = 1'b0;

        // Single request, STEPS=5: five shift cycles, then delivery
        req_b = 4'b0001;
        push_b(3'd0, 22'h000020);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_b = '0;
            chk("t3_sh_en", 32'(sh_b), 1);
        end
        @(negedge clk);
        chk("t3_rvalid_latency", 32'(rvalid_b), 1);
        @(negedge clk);
        chk("t3_rdata_hold", 32'(rdata_b), 32'h000020);

        // Reset during the 3rd SHIFT cycle aborts a grant to requester 1
        req_b = 4'b0010;
        @(negedge clk);
        req_b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_in_shift3", 32'(sh_b), 1);
        rst_b = 1'b1;
        @(negedge clk);
        chk("t4_abort_busy", 32'(busy_b), 0);
        chk("t4_abort_sh_en", 32'(sh_b), 0);
        chk("t4_abort_rvalid", 32'(rvalid_b), 0);
        chk("t4_lfsr_rst_c1", 32'(lrst_b), 1);
        chk("t4_rdata_reset", 32'(rdata_b), 0);
        @(negedge clk);
        chk("t4_lfsr_rst_c2", 32'(lrst_b), 1);
        rst_b = 1'b0;
        @(negedge clk);
        chk("t4_lfsr_rst_after", 32'(lrst_b), 0);
        chk("t4_no_rvalid", 32'(rvalid_b), 0);
        // Before the reset, requester 0 was served last, so with the pointer
        // kept, requester 1 would win here. After the reset, 0 wins.
        req_b = 4'b1111;
        push_b(3'd0, 22'h000020);
        @(negedge clk);
        req_b = '0;
        repeat (7) @(negedge clk);

        // Wrap counter: a level held high counts once
        tick_a = 1'b1;
        @(negedge clk);
        chk("wrap_first_edge", 32'(wrap_a), 1);
        repeat (3) @(negedge clk);
        chk("wrap_level_held", 32'(wrap_a), 1);
        tick_a = 1'b0;
        @(negedge clk);
        tick_a = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        @(negedge clk);
        chk("wrap_two_edges", 32'(wrap_a), 2);
        for (int i = 0; i < 300; i++) begin
            tick_a = 1'b1;
            @(negedge clk);
            tick_a = 1'b0;
            @(negedge clk);
            if (i == 251) chk("wrap_254", 32'(wrap_a), 254);
        end
        chk("wrap_saturate", 32'(wrap_a), 255);

        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
